// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// ADDI_SUPPORT_EN adds the ADDI_EXEC/ADDI_WB states.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9
`ifdef ADDI_SUPPORT_EN
        ,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    // States that occupy the memory port and therefore stretch by MEM_LATENCY
    function automatic logic is_mem_state(state_e s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/main_ctrl_decode.sv
// Moore output decode: state and wait count to datapath strobes.
// ADDI_SUPPORT_EN adds decode for the ADDI states.
module main_ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  state_e     state,
    input  logic [3:0] wait_cnt,
    output ctrl_t      ctrl
);

    localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

    always_comb begin
        ctrl = '0;
        unique case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                if (wait_cnt == LAST) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_ALU;
                end
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef ADDI_SUPPORT_EN
            ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath.
// ADDI_SUPPORT_EN enables the ADDI instruction path.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       last;
    logic       illegal;
    ctrl_t      ctrl, ctrl_g;

    assign last = (wait_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        unique case (state_q)
            FETCH:     if (last) state_d = DECODE;
            DECODE: begin
                unique case (opcode)
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef ADDI_SUPPORT_EN
                    OP_ADDI:      state_d = ADDI_EXEC;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (last) state_d = MEM_WB;
            MEM_WRITE: if (last) state_d = FETCH;
            EXECUTE:   state_d = R_WB;
`ifdef ADDI_SUPPORT_EN
            ADDI_EXEC: state_d = ADDI_WB;
`endif
            default:   state_d = FETCH;
        endcase
    end

    // Counter only runs while a memory state is still waiting
    always_comb begin
        wait_d = '0;
        unique case (1'b1)
            is_mem_state(state_q) && !last: wait_d = wait_q + 4'd1;
            default:                        wait_d = '0;
        endcase
    end

    main_ctrl_decode #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_decode (
        .state    (state_q),
        .wait_cnt (wait_q),
        .ctrl     (ctrl)
    );

    assign ctrl_g      = reset ? '0 : ctrl;
    assign PCWrite     = ctrl_g.pc_write;
    assign PCWriteCond = ctrl_g.pc_write_cond;
    assign IorD        = ctrl_g.i_or_d;
    assign MemRead     = ctrl_g.mem_read;
    assign MemWrite    = ctrl_g.mem_write;
    assign MemtoReg    = ctrl_g.mem_to_reg;
    assign IRWrite     = ctrl_g.ir_write;
    assign PCSource    = ctrl_g.pc_source;
    assign ALUOp       = ctrl_g.alu_op;
    assign ALUSrcA     = ctrl_g.alu_src_a;
    assign ALUSrcB     = ctrl_g.alu_src_b;
    assign RegWrite    = ctrl_g.reg_write;
    assign RegDst      = ctrl_g.reg_dst;
    assign illegal_op  = illegal & ~reset;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control at MEM_LATENCY 1, 2 and 3.
module tb_multicycle_main_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst [3];
    logic [5:0] opc [3];
    logic       pcw [3];
    logic       pcwc [3];
    logic       iord [3];
    logic       mr [3];
    logic       mw [3];
    logic       m2r [3];
    logic       irw [3];
    logic [1:0] pcs [3];
    logic [1:0] aop [3];
    logic       asa [3];
    logic [1:0] asb [3];
    logic       rw [3];
    logic       rd [3];
    logic       ill [3];
    logic [3:0] sdbg [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_main_control #(
            .MEM_LATENCY(g + 1)
        ) u_dut (
            .clk         (clk),
            .reset       (rst[g]),
            .opcode      (opc[g]),
            .PCWrite     (pcw[g]),
            .PCWriteCond (pcwc[g]),
            .IorD        (iord[g]),
            .MemRead     (mr[g]),
            .MemWrite    (mw[g]),
            .MemtoReg    (m2r[g]),
            .IRWrite     (irw[g]),
            .PCSource    (pcs[g]),
            .ALUOp       (aop[g]),
            .ALUSrcA     (asa[g]),
            .ALUSrcB     (asb[g]),
            .RegWrite    (rw[g]),
            .RegDst      (rd[g]),
            .illegal_op  (ill[g]),
            .state_dbg   (sdbg[g])
        );
    end

    typedef struct {
        logic [20:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Expected output vector built from the per-state output table
    function automatic logic [20:0] ev(state_e s, bit fin, bit il);
        logic       e_pcw, e_pcwc, e_iord, e_mr, e_mw, e_m2r, e_irw;
        logic       e_asa, e_rw, e_rd;
        logic [1:0] e_pcs, e_aop, e_asb;
        {e_pcw, e_pcwc, e_iord, e_mr, e_mw, e_m2r, e_irw} = '0;
        {e_asa, e_rw, e_rd, e_pcs, e_aop, e_asb} = '0;
        case (s)
            FETCH: begin
                e_mr  = 1'b1;
                e_asb = 2'b01;
                e_irw = fin;
                e_pcw = fin;
            end
            DECODE:    e_asb = 2'b11;
            MEM_ADDR:  begin e_asa = 1'b1; e_asb = 2'b10; end
            MEM_READ:  begin e_mr = 1'b1; e_iord = 1'b1; end
            MEM_WB:    begin e_rw = 1'b1; e_m2r = 1'b1; end
            MEM_WRITE: begin e_mw = 1'b1; e_iord = 1'b1; end
            EXECUTE:   begin e_asa = 1'b1; e_aop = 2'b10; end
            R_WB:      begin e_rw = 1'b1; e_rd = 1'b1; end
            BRANCH: begin
                e_asa  = 1'b1;
                e_aop  = 2'b01;
                e_pcwc = 1'b1;
                e_pcs  = 2'b01;
            end
            JUMP:      begin e_pcw = 1'b1; e_pcs = 2'b10; end
`ifdef ADDI_SUPPORT_EN
            ADDI_EXEC: begin e_asa = 1'b1; e_asb = 2'b10; end
            ADDI_WB:   e_rw = 1'b1;
`endif
            default: ;
        endcase
        return {s, e_pcw, e_pcwc, e_iord, e_mr, e_mw, e_m2r, e_irw,
                e_pcs, e_aop, e_asa, e_asb, e_rw, e_rd, il};
    endfunction

    function automatic logic [20:0] obs(int k);
        return {sdbg[k], pcw[k], pcwc[k], iord[k], mr[k], mw[k], m2r[k],
                irw[k], pcs[k], aop[k], asa[k], asb[k], rw[k], rd[k],
                ill[k]};
    endfunction

    task automatic push(state_e s, bit fin, bit il, string tag);
        exp_t e;
        e.v   = ev(s, fin, il);
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_rst(state_e s, string tag);
        exp_t e;
        e.v   = {s, 17'b0};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check(int k);
        exp_t        e;
        logic [20:0] o;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty dut=%0d got=none exp=entry", k);
        end else begin
            e = sb.pop_front();
            o = obs(k);
            assert (o === e.v) else begin
                bad++;
                $error("FAIL %s dut=%0d got=%h exp=%h", e.tag, k, o, e.v);
            end
        end
    endtask

    task automatic step(int k);
        check(k);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int k);
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 64) begin
            step(k);
            guard++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $error("FAIL drain_bound dut=%0d got=%0d exp=0", k, sb.size());
            sb.delete();
        end
    endtask

    task automatic start(int k);
        rst[k] = 1'b1;
        @(posedge clk);
        #1;
        rst[k] = 1'b0;
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            opc[k] = 6'b000000;
        end

        repeat (2) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                push_rst(FETCH, "reset_hold");
                check(k);
            end
        end

        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        #1;
        push(FETCH, 1, 0, "release_L1");
        check(0);
        push(FETCH, 0, 0, "release_L2");
        check(1);
        push(FETCH, 0, 0, "release_L3");
        check(2);

        // R-type, L=1
        opc[0] = OP_RTYPE;
        start(0);
        push(FETCH, 1, 0, "r_fetch");
        push(DECODE, 0, 0, "r_decode");
        push(EXECUTE, 0, 0, "r_exec");
        push(R_WB, 0, 0, "r_wb");
        push(FETCH, 1, 0, "r_next_fetch");
        drain(0);

        // lw, L=3
        opc[2] = OP_LW;
        start(2);
        push(FETCH, 0, 0, "lw_fetch0");
        push(FETCH, 0, 0, "lw_fetch1");
        push(FETCH, 1, 0, "lw_fetch2");
        push(DECODE, 0, 0, "lw_decode");
        push(MEM_ADDR, 0, 0, "lw_addr");
        push(MEM_READ, 0, 0, "lw_read0");
        push(MEM_READ, 0, 0, "lw_read1");
        push(MEM_READ, 0, 0, "lw_read2");
        push(MEM_WB, 0, 0, "lw_wb");
        push(FETCH, 0, 0, "lw_next_fetch");
        drain(2);

        // sw, L=2
        opc[1] = OP_SW;
        start(1);
        push(FETCH, 0, 0, "sw_fetch0");
        push(FETCH, 1, 0, "sw_fetch1");
        push(DECODE, 0, 0, "sw_decode");
        push(MEM_ADDR, 0, 0, "sw_addr");
        push(MEM_WRITE, 0, 0, "sw_write0");
        push(MEM_WRITE, 0, 0, "sw_write1");
        push(FETCH, 0, 0, "sw_next_fetch");
        drain(1);

        // beq and j, L=1
        opc[0] = OP_BEQ;
        start(0);
        push(FETCH, 1, 0, "beq_fetch");
        push(DECODE, 0, 0, "beq_decode");
        push(BRANCH, 0, 0, "beq_branch");
        push(FETCH, 1, 0, "beq_next_fetch");
        drain(0);

        opc[0] = OP_J;
        start(0);
        push(FETCH, 1, 0, "j_fetch");
        push(DECODE, 0, 0, "j_decode");
        push(JUMP, 0, 0, "j_jump");
        push(FETCH, 1, 0, "j_next_fetch");
        drain(0);

        // Unsupported opcode
        opc[0] = 6'b111111;
        start(0);
        push(FETCH, 1, 0, "ill_fetch");
        push(DECODE, 0, 1, "ill_decode");
        push(FETCH, 1, 0, "ill_next_fetch");
        push(DECODE, 0, 1, "ill_decode2");
        drain(0);

        // addi
        opc[0] = OP_ADDI;
        start(0);
        push(FETCH, 1, 0, "addi_fetch");
`ifdef ADDI_SUPPORT_EN
        push(DECODE, 0, 0, "addi_decode");
        push(ADDI_EXEC, 0, 0, "addi_exec");
        push(ADDI_WB, 0, 0, "addi_wb");
`else
        push(DECODE, 0, 1, "addi_illegal");
`endif
        push(FETCH, 1, 0, "addi_next_fetch");
        drain(0);

        // Reset during the first MEM_WRITE cycle, L=2
        opc[1] = OP_SW;
        start(1);
        push(FETCH, 0, 0, "swr_fetch0");
        push(FETCH, 1, 0, "swr_fetch1");
        push(DECODE, 0, 0, "swr_decode");
        push(MEM_ADDR, 0, 0, "swr_addr");
        drain(1);
        rst[1] = 1'b1;
        #1;
        push_rst(MEM_WRITE, "swr_gated");
        step(1);
        rst[1] = 1'b0;
        #1;
        push(FETCH, 0, 0, "swr_after0");
        push(FETCH, 1, 0, "swr_after1");
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
